// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between dcache (0) and icache (1).
// An owner FIFO remembers which master issued each outstanding read so read beats route back.
module sdram_arbiter #(
    parameter int RD_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dcache_sdram_request,
    input  logic [25:0] dcache_sdram_addr,
    input  logic        dcache_sdram_write,
    input  logic        dcache_sdram_burst,
    input  logic [3:0]  dcache_sdram_wstrb,
    input  logic [31:0] dcache_sdram_wdata,
    output logic        dcache_sdram_ready,
    output logic        dcache_sdram_rvalid,
    output logic        dcache_sdram_complete,
    input  logic        icache_sdram_request,
    input  logic [25:0] icache_sdram_addr,
    input  logic        icache_sdram_burst,
    input  logic [31:0] icache_sdram_wdata,
    output logic        icache_sdram_ready,
    output logic        icache_sdram_rvalid,
    output logic        icache_sdram_complete,
    output logic [31:0] sdram_rdata,
    output logic [25:0] sdram_raddress,
    input  logic        sdram_ready,
    output logic        sdram_request,
    output logic [25:0] sdram_addr,
    output logic        sdram_write,
    output logic        sdram_burst,
    output logic [3:0]  sdram_wstrb,
    output logic [31:0] sdram_wdata,
    input  logic        sdram_rvalid,
    input  logic [31:0] sdram_rdata_in,
    input  logic [25:0] sdram_raddress_in,
    input  logic        sdram_complete,
    output logic        arb_error
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;

    logic [RD_DEPTH-1:0] owner;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       rd_count;
    logic                prio;

    logic full;
    logic nonempty;
    logic elig0;
    logic elig1;
    logic grant_valid;
    logic grant_id;
    logic transfer;
    logic push;
    logic pop;
    logic head_id;

    assign full     = (rd_count == CW'(RD_DEPTH));
    assign nonempty = (rd_count != '0);
    assign head_id  = owner[head];

    // Request inputs are ignored while reset is asserted so every output drops at once.
    assign elig0 = reset & dcache_sdram_request & (dcache_sdram_write | ~full);
    assign elig1 = reset & icache_sdram_request & ~full;

    assign grant_valid = elig0 | elig1;
    assign grant_id    = (elig0 & elig1) ? prio : elig1;
    assign transfer    = grant_valid & sdram_ready;
    assign push        = transfer & (grant_id | ~dcache_sdram_write);
    assign pop         = sdram_rvalid & sdram_complete & nonempty;

    always_comb begin
        sdram_request = grant_valid;
        sdram_addr    = '0;
        sdram_write   = 1'b0;
        sdram_burst   = 1'b0;
        sdram_wstrb   = '0;
        sdram_wdata   = '0;
        if (grant_valid && !grant_id) begin
            sdram_addr  = dcache_sdram_addr;
            sdram_write = dcache_sdram_write;
            sdram_burst = dcache_sdram_burst;
            sdram_wstrb = dcache_sdram_wstrb;
            sdram_wdata = dcache_sdram_wdata;
        end else if (grant_valid) begin
            sdram_addr  = icache_sdram_addr;
            sdram_burst = icache_sdram_burst;
            sdram_wdata = icache_sdram_wdata;
        end
    end

    assign dcache_sdram_ready    = transfer & ~grant_id;
    assign icache_sdram_ready    = transfer & grant_id;
    assign dcache_sdram_rvalid   = reset & sdram_rvalid & nonempty & ~head_id;
    assign icache_sdram_rvalid   = reset & sdram_rvalid & nonempty & head_id;
    assign dcache_sdram_complete = reset & sdram_complete & nonempty & ~head_id;
    assign icache_sdram_complete = reset & sdram_complete & nonempty & head_id;
    assign sdram_rdata           = reset ? sdram_rdata_in : '0;
    assign sdram_raddress        = reset ? sdram_raddress_in : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner     <= '0;
            head      <= '0;
            tail      <= '0;
            rd_count  <= '0;
            prio      <= 1'b0;
            arb_error <= 1'b0;
        end else begin
            if (push) begin
                owner[tail] <= grant_id;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            rd_count <= rd_count + CW'(push) - CW'(pop);
            if (transfer) begin
                prio <= ~grant_id;
            end
            // A beat with nothing outstanding is dropped but remembered.
            if (sdram_rvalid && !nonempty) begin
                arb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant order, owner-FIFO routing, full stall, error and reset.
module tb_sdram_arbiter;

    logic        clock;
    logic        reset;
    logic        dcache_sdram_request;
    logic [25:0] dcache_sdram_addr;
    logic        dcache_sdram_write;
    logic        dcache_sdram_burst;
    logic [3:0]  dcache_sdram_wstrb;
    logic [31:0] dcache_sdram_wdata;
    logic        dcache_sdram_ready;
    logic        dcache_sdram_rvalid;
    logic        dcache_sdram_complete;
    logic        icache_sdram_request;
    logic [25:0] icache_sdram_addr;
    logic        icache_sdram_burst;
    logic [31:0] icache_sdram_wdata;
    logic        icache_sdram_ready;
    logic        icache_sdram_rvalid;
    logic        icache_sdram_complete;
    logic [31:0] sdram_rdata;
    logic [25:0] sdram_raddress;
    logic        sdram_ready;
    logic        sdram_request;
    logic [25:0] sdram_addr;
    logic        sdram_write;
    logic        sdram_burst;
    logic [3:0]  sdram_wstrb;
    logic [31:0] sdram_wdata;
    logic        sdram_rvalid;
    logic [31:0] sdram_rdata_in;
    logic [25:0] sdram_raddress_in;
    logic        sdram_complete;
    logic        arb_error;

    int tests_run = 0;
    int tests_failed = 0;

    sdram_arbiter #(.RD_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .dcache_sdram_request(dcache_sdram_request), .dcache_sdram_addr(dcache_sdram_addr),
        .dcache_sdram_write(dcache_sdram_write), .dcache_sdram_burst(dcache_sdram_burst),
        .dcache_sdram_wstrb(dcache_sdram_wstrb), .dcache_sdram_wdata(dcache_sdram_wdata),
        .dcache_sdram_ready(dcache_sdram_ready), .dcache_sdram_rvalid(dcache_sdram_rvalid),
        .dcache_sdram_complete(dcache_sdram_complete),
        .icache_sdram_request(icache_sdram_request), .icache_sdram_addr(icache_sdram_addr),
        .icache_sdram_burst(icache_sdram_burst), .icache_sdram_wdata(icache_sdram_wdata),
        .icache_sdram_ready(icache_sdram_ready), .icache_sdram_rvalid(icache_sdram_rvalid),
        .icache_sdram_complete(icache_sdram_complete),
        .sdram_rdata(sdram_rdata), .sdram_raddress(sdram_raddress),
        .sdram_ready(sdram_ready), .sdram_request(sdram_request), .sdram_addr(sdram_addr),
        .sdram_write(sdram_write), .sdram_burst(sdram_burst), .sdram_wstrb(sdram_wstrb),
        .sdram_wdata(sdram_wdata), .sdram_rvalid(sdram_rvalid), .sdram_rdata_in(sdram_rdata_in),
        .sdram_raddress_in(sdram_raddress_in), .sdram_complete(sdram_complete),
        .arb_error(arb_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        dcache_sdram_request = 0; dcache_sdram_addr = '0; dcache_sdram_write = 0;
        dcache_sdram_burst = 0; dcache_sdram_wstrb = '0; dcache_sdram_wdata = '0;
        icache_sdram_request = 0; icache_sdram_addr = '0; icache_sdram_burst = 0;
        icache_sdram_wdata = '0; sdram_ready = 0; sdram_rvalid = 0; sdram_rdata_in = '0;
        sdram_raddress_in = '0; sdram_complete = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests_run++;
        if (sdram_request !== 1'b0 || arb_error !== 1'b0 || dut.rd_count !== 3'd0 || dut.prio !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: req=%b err=%b count=%0d prio=%b, want 0 0 0 0",
                     sdram_request, arb_error, dut.rd_count, dut.prio);
        end
    endtask

    task automatic test_round_robin_burst();
        apply_reset();
        dcache_sdram_request = 1; dcache_sdram_addr = 26'h0000100; dcache_sdram_burst = 1;
        dcache_sdram_wdata = 32'hD0D0_0001;
        icache_sdram_request = 1; icache_sdram_addr = 26'h0200000; icache_sdram_burst = 1;
        icache_sdram_wdata = 32'h1C1C_0002;
        sdram_ready = 1;
        #1;
        tests_run++;
        if (dcache_sdram_ready !== 1 || icache_sdram_ready !== 0 || sdram_addr !== 26'h0000100 ||
            sdram_burst !== 1 || sdram_write !== 0 || sdram_wdata !== 32'hD0D0_0001) begin
            tests_failed++;
            $display("FAIL rr_first_grant: dready=%b iready=%b addr=%h wdata=%h, want 1 0 0000100 d0d00001",
                     dcache_sdram_ready, icache_sdram_ready, sdram_addr, sdram_wdata);
        end
        tick();
        dcache_sdram_request = 0;
        #1;
        tests_run++;
        if (icache_sdram_ready !== 1 || dcache_sdram_ready !== 0 || sdram_addr !== 26'h0200000 ||
            sdram_wstrb !== 4'b0 || sdram_wdata !== 32'h1C1C_0002) begin
            tests_failed++;
            $display("FAIL rr_second_grant: iready=%b dready=%b addr=%h, want 1 0 0200000",
                     icache_sdram_ready, dcache_sdram_ready, sdram_addr);
        end
        tick();
        icache_sdram_request = 0;
        sdram_ready = 0;
        tests_run++;
        if (dut.rd_count !== 3'd2) begin
            tests_failed++;
            $display("FAIL fifo_two_entries: rd_count=%0d want 2", dut.rd_count);
        end
        for (int b = 0; b < 32; b++) begin
            sdram_rvalid = 1;
            sdram_complete = (b == 15 || b == 31);
            sdram_rdata_in = 32'hA000_0000 + b;
            sdram_raddress_in = 26'h0000100 + b;
            #1;
            tests_run++;
            if (dcache_sdram_rvalid !== (b < 16) || icache_sdram_rvalid !== (b >= 16) ||
                dcache_sdram_complete !== (b == 15) || icache_sdram_complete !== (b == 31) ||
                sdram_rdata !== 32'hA000_0000 + b || sdram_raddress !== 26'h0000100 + b) begin
                tests_failed++;
                $display("FAIL route_beat_%0d: drv=%b irv=%b dc=%b ic=%b rdata=%h", b,
                         dcache_sdram_rvalid, icache_sdram_rvalid, dcache_sdram_complete,
                         icache_sdram_complete, sdram_rdata);
            end
            tick();
        end
        sdram_rvalid = 0;
        sdram_complete = 0;
        tests_run++;
        if (dut.rd_count !== 3'd0 || arb_error !== 0) begin
            tests_failed++;
            $display("FAIL burst_drain: rd_count=%0d err=%b want 0 0", dut.rd_count, arb_error);
        end
    endtask

    task automatic test_fifo_full_and_write();
        apply_reset();
        dcache_sdram_request = 1; dcache_sdram_addr = 26'h0000040;
        icache_sdram_request = 1; icache_sdram_addr = 26'h0000080;
        sdram_ready = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            tests_run++;
            if (c < 4) begin
                if (dcache_sdram_ready !== (c % 2 == 0) || icache_sdram_ready !== (c % 2 == 1)) begin
                    tests_failed++;
                    $display("FAIL alternate_%0d: dready=%b iready=%b", c,
                             dcache_sdram_ready, icache_sdram_ready);
                end
            end else begin
                if (dcache_sdram_ready !== 0 || icache_sdram_ready !== 0 || sdram_request !== 0 ||
                    dut.rd_count !== 3'd4) begin
                    tests_failed++;
                    $display("FAIL full_stall_%0d: dready=%b iready=%b req=%b count=%0d want 0 0 0 4",
                             c, dcache_sdram_ready, icache_sdram_ready, sdram_request, dut.rd_count);
                end
            end
            tick();
        end
        dcache_sdram_write = 1; dcache_sdram_wstrb = 4'b0011; dcache_sdram_wdata = 32'hCAFE_F00D;
        #1;
        tests_run++;
        if (dcache_sdram_ready !== 1 || icache_sdram_ready !== 0 || sdram_write !== 1 ||
            sdram_wstrb !== 4'b0011 || sdram_wdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL write_when_full: dready=%b write=%b wstrb=%b wdata=%h want 1 1 0011 cafef00d",
                     dcache_sdram_ready, sdram_write, sdram_wstrb, sdram_wdata);
        end
        tick();
        dcache_sdram_write = 0; dcache_sdram_wstrb = '0; dcache_sdram_wdata = '0;
        icache_sdram_request = 0;
        tests_run++;
        if (dut.rd_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL write_not_pushed: rd_count=%0d want 4", dut.rd_count);
        end
        // Full FIFO, single-beat read returns while a dcache read is pending.
        sdram_rvalid = 1; sdram_complete = 1;
        #1;
        tests_run++;
        if (dcache_sdram_ready !== 0 || dcache_sdram_rvalid !== 1 || icache_sdram_rvalid !== 0) begin
            tests_failed++;
            $display("FAIL push_blocked_on_pop: dready=%b drv=%b irv=%b want 0 1 0",
                     dcache_sdram_ready, dcache_sdram_rvalid, icache_sdram_rvalid);
        end
        tick();
        sdram_rvalid = 0; sdram_complete = 0;
        #1;
        tests_run++;
        if (dut.rd_count !== 3'd3 || dcache_sdram_ready !== 1) begin
            tests_failed++;
            $display("FAIL accept_after_pop: count=%0d dready=%b want 3 1", dut.rd_count, dcache_sdram_ready);
        end
        tick();
        dcache_sdram_request = 0;
        tests_run++;
        if (dut.rd_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL refill: rd_count=%0d want 4", dut.rd_count);
        end
    endtask

    task automatic test_ready_low_holds_prio();
        apply_reset();
        dcache_sdram_request = 1; dcache_sdram_write = 1; dcache_sdram_wstrb = 4'hF;
        sdram_ready = 1;
        tick();
        dcache_sdram_write = 0; dcache_sdram_wstrb = '0;
        icache_sdram_request = 1;
        sdram_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++;
            if (dcache_sdram_ready !== 0 || icache_sdram_ready !== 0 || dut.prio !== 1'b1) begin
                tests_failed++;
                $display("FAIL ready_low_%0d: dready=%b iready=%b prio=%b want 0 0 1", c,
                         dcache_sdram_ready, icache_sdram_ready, dut.prio);
            end
            tick();
        end
        sdram_ready = 1;
        #1;
        tests_run++;
        if (icache_sdram_ready !== 1 || dcache_sdram_ready !== 0) begin
            tests_failed++;
            $display("FAIL ready_rise_follows_prio: iready=%b dready=%b want 1 0",
                     icache_sdram_ready, dcache_sdram_ready);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_empty_beat_error();
        apply_reset();
        sdram_rvalid = 1; sdram_complete = 1; sdram_rdata_in = 32'h1234_5678;
        #1;
        tests_run++;
        if (dcache_sdram_rvalid !== 0 || icache_sdram_rvalid !== 0 || arb_error !== 0) begin
            tests_failed++;
            $display("FAIL empty_beat_dropped: drv=%b irv=%b err=%b want 0 0 0",
                     dcache_sdram_rvalid, icache_sdram_rvalid, arb_error);
        end
        tick();
        sdram_rvalid = 0; sdram_complete = 0;
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (arb_error !== 1 || dut.rd_count !== 3'd0) begin
                tests_failed++;
                $display("FAIL error_sticky_%0d: err=%b count=%0d want 1 0", c, arb_error, dut.rd_count);
            end
            tick();
        end
        reset = 0;
        #1;
        tests_run++;
        if (arb_error !== 0) begin
            tests_failed++;
            $display("FAIL error_cleared_by_reset: err=%b want 0", arb_error);
        end
        tick();
        reset = 1;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        dcache_sdram_request = 1; dcache_sdram_addr = 26'h0000300; dcache_sdram_burst = 1;
        icache_sdram_request = 1; icache_sdram_addr = 26'h0000700;
        sdram_ready = 1;
        tick();
        dcache_sdram_request = 0;
        tick();
        icache_sdram_request = 0;
        for (int b = 0; b < 5; b++) begin
            sdram_rvalid = 1; sdram_rdata_in = 32'hB000_0000 + b;
            tick();
        end
        dcache_sdram_request = 1; icache_sdram_request = 1;
        reset = 0;
        #1;
        tests_run++;
        if (dcache_sdram_ready !== 0 || icache_sdram_ready !== 0 || sdram_request !== 0 ||
            sdram_addr !== 26'h0 || dcache_sdram_rvalid !== 0 || icache_sdram_rvalid !== 0 ||
            sdram_rdata !== 32'h0 || arb_error !== 0) begin
            tests_failed++;
            $display("FAIL reset_outputs_low: dr=%b ir=%b req=%b addr=%h drv=%b rdata=%h err=%b",
                     dcache_sdram_ready, icache_sdram_ready, sdram_request, sdram_addr,
                     dcache_sdram_rvalid, sdram_rdata, arb_error);
        end
        tick();
        dcache_sdram_request = 0; icache_sdram_request = 0;
        reset = 1;
        #1;
        tests_run++;
        if (dut.rd_count !== 3'd0 || dut.prio !== 1'b0 || arb_error !== 0 || dcache_sdram_rvalid !== 0) begin
            tests_failed++;
            $display("FAIL after_release: count=%0d prio=%b err=%b drv=%b want 0 0 0 0",
                     dut.rd_count, dut.prio, arb_error, dcache_sdram_rvalid);
        end
        tick();
        sdram_rvalid = 0;
        tests_run++;
        if (arb_error !== 1) begin
            tests_failed++;
            $display("FAIL stale_beat_error: err=%b want 1", arb_error);
        end
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_round_robin_burst();
        test_fifo_full_and_write();
        test_ready_low_holds_prio();
        test_empty_beat_error();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between the data cache (master 0) and the instruction cache miss path (master 1).
- Downstream it presents the same request/response interface as the data-cache-to-SDRAM port.
- Requests are granted round-robin with a zero-latency combinational mux.
- An owner FIFO records which master issued each outstanding read, so that read beats are routed back to the correct master.

Parameters:
- RD_DEPTH, 4, maximum outstanding reads tracked (power of 2, at least 2).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
dcache_sdram_request  in  1  dcache request
dcache_sdram_addr  in  26  dcache address
dcache_sdram_write  in  1  0 = read, 1 = write
dcache_sdram_burst  in  1  1 = 16-beat read burst
dcache_sdram_wstrb  in  4  byte enables
dcache_sdram_wdata  in  32  write data; tag for reads
dcache_sdram_ready  out  1  dcache request accepted this cycle when high with request
dcache_sdram_rvalid  out  1  read beat for dcache
dcache_sdram_complete  out  1  final beat for dcache
icache_sdram_request  in  1  icache request (read only)
icache_sdram_addr  in  26  icache address
icache_sdram_burst  in  1  1 = 16-beat read burst
icache_sdram_wdata  in  32  read tag
icache_sdram_ready  out  1  icache request accepted
icache_sdram_rvalid  out  1  read beat for icache
icache_sdram_complete  out  1  final beat for icache
sdram_rdata, sdram_raddress  out  32, 26  broadcast copies of the downstream read data and read address to both masters
sdram_ready  in  1  controller accepts a request
sdram_request  out  1  request to controller
sdram_addr  out  26  muxed address
sdram_write  out  1  muxed write flag (0 for icache)
sdram_burst  out  1  muxed burst flag
sdram_wstrb  out  4  muxed strobes (4'b0 for icache)
sdram_wdata  out  32  muxed write data / tag
sdram_rvalid  in  1  read beat valid
sdram_rdata_in  in  32  read data
sdram_raddress_in  in  26  read address
sdram_complete  in  1  final (or only) beat of a read
arb_error  out  1  sticky: read beat arrived while the owner FIFO was empty

Behaviour:
- Transfer definition: a transfer occurs on a clock edge where sdram_request and sdram_ready are both high.
- Eligibility: a master is eligible when its request is high. A read is additionally blocked while rd_count == RD_DEPTH; push is checked against the registered count and does not use a same-cycle pop. Writes are never blocked.
- Grant is combinational:
  - If only one master is eligible, it is granted.
  - If both are eligible, the master selected by the priority pointer prio is granted.
  - prio resets to 0 (dcache).
  - After each transfer, prio moves to the non-granted master.
  - No grant, and no movement of prio, occurs without a transfer.
- Downstream mux: sdram_request is high iff a grant exists. All sdram_* request fields come from the granted master; otherwise they are 0.
- Upstream ready: <m>_sdram_ready = sdram_ready & grant==m. Requests must hold stable until accepted (master's obligation).
- Owner FIFO:
  - Push of the master ID on every read transfer; writes are not pushed.
  - Pop on sdram_rvalid & sdram_complete.
  - Simultaneous push and pop leaves rd_count unchanged, with the head and tail pointers both advancing.
  - Pointers wrap modulo RD_DEPTH.
- Response routing:
  - <m>_sdram_rvalid = sdram_rvalid & count != 0 & head == m.
  - <m>_sdram_complete = sdram_complete & the same qualification.
  - rdata and raddress are passed combinationally to both masters with zero latency.
- Empty-FIFO beat: an rvalid arriving with count == 0 is dropped, with no rvalid to either master and no pop. arb_error is set and stays set until reset.
- Reset (asynchronous, active-low):
  - Clears FIFO pointers, rd_count, prio and arb_error.
  - All outputs go low immediately because request inputs are ignored during reset. Outstanding reads are forgotten.
  - Beats arriving after reset release with an empty FIFO set arb_error.
- State: rd_count width is clog2(RD_DEPTH)+1 bits.

Test Plan:
1. Both masters request reads at addr 0x0000100 (dcache) and 0x0200000 (icache), burst = 1, sdram_ready held high:
   - Grant order is dcache then icache.
   - FIFO holds {0,1}.
   - 16 beats with complete on the 16th route to dcache only.
   - The next 16 beats route to icache.
   - rd_count ends at 0.
2. Continuous requests from both masters for 8 cycles with no responses (RD_DEPTH = 4):
   - Transfers strictly alternate 0,1,0,1.
   - Reads then stall: both ready = 0 while rd_count = 4.
   - A dcache write with wstrb = 4'b0011 is still accepted.
3. FIFO full; a single-beat read (rvalid + complete) arrives in the same cycle as a pending request:
   - The request is not accepted in that cycle and is accepted the next cycle.
   - rd_count goes 4→3→4.
4. sdram_ready = 0 for 5 cycles with both masters requesting:
   - No ready to either master.
   - prio is unchanged.
   - The first transfer after ready rises follows prio.
5. sdram_rvalid pulse with an empty FIFO:
   - Neither master sees rvalid.
   - arb_error = 1 and stays at 1 until reset is driven to 0.
6. reset driven low mid-burst (after 5 of 16 beats):
   - Outputs are 0 immediately.
   - After release, rd_count = 0, prio = 0, and arb_error = 0.
